instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- PC-generation and IF/ID pipeline stage sitting directly upstream of the combinational instruction memory.
- Drives the word-aligned fetch address and captures the returned instruction into the IF/ID register for decode.
- Handles sequential PC+4, branch/jump redirects from EX, pipeline stalls, and a sticky fault halt on misaligned or out-of-range fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_ADDR_BITS, 16, byte-address width backed by instruction memory (16384 words); any PC with bits [31:IMEM_ADDR_BITS] nonzero is out of range.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID contents.
- redirect_valid  in  1  EX stage: taken branch/jump this cycle.
- redirect_target  in  32  new PC when redirect_valid=1.
- imem_addr  out  32  read_address to instruction memory; equals the PC register.
- imem_instr  in  32  instruction word from memory, same cycle (combinational).
- if_valid  out  1  IF/ID register holds a real instruction.
- if_pc  out  32  PC of the instruction in IF/ID.
- if_pc_plus4  out  32  if_pc + 4 (mod 2^32).
- if_instr  out  32  instruction in IF/ID.
- fetch_fault  out  1  sticky: fetch unit halted.
- fault_pc  out  32  offending PC/target that caused the halt.
- fetch_count  out  32  count of instructions delivered into IF/ID (wraps).

Behaviour:
- Reset (sync): pc=RESET_PC; if_valid=0; if_pc=0; if_pc_plus4=0; if_instr=32'h0000_0013 (NOP); fetch_fault=0; fault_pc=0; fetch_count=0; state=RUN.
- FSM states: RUN, HALT. Only reset leaves HALT.
- RUN, priority per cycle (highest first):
  1. redirect_valid=1, target[1:0]!=0 or target out of range -> state=HALT, fault_pc=target, if_valid=0.
  2. redirect_valid=1 (legal) -> pc=target; if_valid=0 (bubble), overriding stall; if_instr=NOP; fetch_count unchanged.
  3. stall=1 -> pc, if_* and fetch_count all hold.
  4. Current pc out of range -> state=HALT, fault_pc=pc, if_valid=0.
  5. Otherwise: if_pc=pc; if_pc_plus4=pc+4; if_instr=imem_instr; if_valid=1; pc=pc+4; fetch_count+=1.
- Latency: an instruction at PC appears on if_* the cycle after pc=PC is presented. After a redirect there is one bubble cycle, then the target instruction is valid.
- HALT: fetch_fault=1; if_valid=0; pc holds; stall and redirect are ignored.
- imem_addr is always the pc register (no combinational path from redirect to imem_addr).
- Arithmetic: all +4 is mod 2^32. 0xFFFF_FFFC wraps to 0, but is already out of range and halts first unless IMEM_ADDR_BITS=32.
- reset asserted mid-stall, mid-redirect or in HALT: reset wins unconditionally.

Decomposition:
- Shared package (riscv_pkg): NOP_INSTR=32'h0000_0013, RESET_PC default, fetch FSM state enum {RUN, HALT}.
- One natural sub-module, if_id_reg: a holding register with load/hold/bubble controls for pc, pc_plus4, instr and valid. The PC/FSM logic stays in instruction_fetch.

Test Plan:
- Reset, then run 4 cycles with memory 0x00..0x0C = A,B,C,D -> if_pc 0,4,8,C with instructions A..D; fetch_count=4; if_valid=1 from cycle 2.
- Stall asserted for 3 cycles at pc=0x8 -> if_pc=0x4 and imem_addr=0x8 held, fetch_count frozen. Release -> if_pc=0x8 next cycle.
- redirect_valid with target=0x100 while stall=1 -> next cycle if_valid=0, imem_addr=0x100; following cycle if_pc=0x100, if_valid=1.
- Redirect target=0x102 -> fetch_fault=1, fault_pc=0x102, if_valid=0. Stays halted across further redirects until reset.
- Sequential fetch reaching pc=0x10000 (IMEM_ADDR_BITS=16) -> HALT with fault_pc=0x10000; last valid if_pc=0xFFFC.
- Reset asserted in the same cycle as redirect_valid -> pc=RESET_PC, if_valid=0, fetch_count=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: NOP encoding, default reset PC and the
// fetch FSM state type.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage : riscv_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load / bubble / squash controls.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load            : capture pc_in / instr_in, mark valid
//   bubble          : mark invalid and replace the instruction with a NOP
//   squash          : mark invalid, leave the payload untouched
//   pc_in, instr_in : fetched PC and instruction word
//   valid, pc, pc_plus4, instr : registered IF/ID contents
// The controls are mutually exclusive by construction in the caller; with
// none asserted the register holds.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic        squash,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            pc       <= 32'h0;
            pc_plus4 <= 32'h0;
            instr    <= NOP_INSTR;
        end else if (load) begin
            valid    <= 1'b1;
            pc       <= pc_in;
            pc_plus4 <= pc_in + 32'd4;
            instr    <= instr_in;
        end else if (bubble) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
        end else if (squash) begin
            valid    <= 1'b0;
        end
    end

endmodule : if_id_reg

// File: rtl/instruction_fetch.sv
// PC generation and IF/ID stage in front of a combinational instruction
// memory. Sequential PC+4 fetch, EX redirects, stalls, and a sticky halt
// on misaligned or out-of-range fetch addresses.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   stall                           : hold PC, IF/ID and fetch count
//   redirect_valid, redirect_target : taken branch/jump from EX
//   imem_addr                       : fetch address (the PC register)
//   imem_instr                      : instruction returned this cycle
//   if_valid, if_pc, if_pc_plus4, if_instr : IF/ID register contents
//   fetch_fault, fault_pc           : sticky halt flag and offending address
//   fetch_count                     : instructions delivered into IF/ID
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_ADDR_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    // Address bits above the backed memory; any set bit is out of range.
    localparam logic [31:0] RANGE_MASK =
        (IMEM_ADDR_BITS >= 32) ? 32'h0 : ~((32'h1 << IMEM_ADDR_BITS) - 32'h1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic [31:0]  count_q, count_d;
    logic         ifid_load, ifid_bubble, ifid_squash;
    logic         target_bad, pc_oor;

    assign target_bad = (redirect_target[1:0] != 2'b00) ||
                        ((redirect_target & RANGE_MASK) != 32'h0);
    assign pc_oor     = (pc_q & RANGE_MASK) != 32'h0;

    // State and PC-side registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
            count_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    // Next-state and IF/ID control, in per-cycle priority order.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fault_d     = fault_q;
        fault_pc_d  = fault_pc_q;
        count_d     = count_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_squash = 1'b0;

        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    if (target_bad) begin
                        state_d     = HALT;
                        fault_d     = 1'b1;
                        fault_pc_d  = redirect_target;
                        ifid_squash = 1'b1;
                    end else begin
                        // Redirect overrides stall and leaves one bubble.
                        pc_d        = redirect_target;
                        ifid_bubble = 1'b1;
                    end
                end else if (stall) begin
                    // Everything holds.
                end else if (pc_oor) begin
                    state_d     = HALT;
                    fault_d     = 1'b1;
                    fault_pc_d  = pc_q;
                    ifid_squash = 1'b1;
                end else begin
                    ifid_load = 1'b1;
                    pc_d      = pc_q + 32'd4;
                    count_d   = count_q + 32'd1;
                end
            end
            HALT: begin
                // Only reset leaves HALT; stall and redirect are ignored.
                fault_d     = 1'b1;
                ifid_squash = 1'b1;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .squash   (ifid_squash),
        .pc_in    (pc_q),
        .instr_in (imem_instr),
        .valid    (if_valid),
        .pc       (if_pc),
        .pc_plus4 (if_pc_plus4),
        .instr    (if_instr)
    );

    assign imem_addr   = pc_q;
    assign fetch_fault = fault_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = count_q;

endmodule : instruction_fetch
